spi_slave_axi_arbiter: RTL and testbench

Shares one single-beat AXI4 master port between two requesters, for example the SPI slave AXI plug and the SPI register/debug path. Each requester has a simple req/gnt/rsp interface. The block arbitrates round-robin, keeps one transaction outstanding at a time, issues AW and W independently with per-channel done flags, and routes B or R responses back to the granted requester. The remaining AXI fields (len=0, size, burst, id, cache, etc.) are tied off at the integration level.

---
 rtl/spi_slave_axi_arbiter.sv | 118 +++++++++++
 tb/tb_spi_slave_axi_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_axi_arbiter.sv
// spi_slave_axi_arbiter: shares one single-beat AXI4 master between two req/gnt/rsp requesters.
// Round-robin by default; define SPI_AXI_ARB_FIXED_PRIO_EN for fixed priority (requester 0 first).
module spi_slave_axi_arbiter #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [1:0]                    req_i,
  input  logic [1:0]                    we_i,
  input  logic [2*AXI_ADDR_WIDTH-1:0]   addr_i,
  input  logic [2*AXI_DATA_WIDTH-1:0]   wdata_i,
  output logic [1:0]                    gnt_o,
  output logic [1:0]                    rsp_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          aw_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     aw_addr_o,
  input  logic                          aw_ready_i,
  output logic                          w_valid_o,
  output logic [AXI_DATA_WIDTH-1:0]     w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0]   w_strb_o,
  output logic                          w_last_o,
  input  logic                          w_ready_i,
  input  logic                          b_valid_i,
  input  logic [1:0]                    b_resp_i,
  output logic                          b_ready_o,
  output logic                          ar_valid_o,
  output logic [AXI_ADDR_WIDTH-1:0]     ar_addr_o,
  input  logic                          ar_ready_i,
  input  logic                          r_valid_i,
  input  logic [AXI_DATA_WIDTH-1:0]     r_data_i,
  input  logic [1:0]                    r_resp_i,
  output logic                          r_ready_o
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;
  state_e                      state_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                        idx_q, err_q, aw_done_q, w_done_q, aw_done_d, w_done_d, win;
  logic [1:0]                  rsp_valid_q;
  logic                        unused_resp;
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
  assign win = !req_i[0];
`else
  logic last_q;
  assign win = (&req_i) ? !last_q : req_i[1];
`endif
  assign unused_resp = ^{r_resp_i[0], b_resp_i[0]};
  // Gated by reset so a request held during reset never shows a grant.
  assign gnt_o       = (state_q == IDLE && axi_aresetn && |req_i) ? {win, !win} : 2'b00;
  assign ar_valid_o  = state_q == RD_ADDR;
  assign r_ready_o   = state_q == RD_DATA;
  assign aw_valid_o  = state_q == WR_REQ && !aw_done_q;
  assign w_valid_o   = state_q == WR_REQ && !w_done_q;
  assign b_ready_o   = state_q == WR_RESP;
  assign aw_addr_o   = addr_q;
  assign ar_addr_o   = addr_q;
  assign w_data_o    = wdata_q;
  assign w_strb_o    = '1;
  assign w_last_o    = 1'b1;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign aw_done_d   = aw_done_q | aw_ready_i;
  assign w_done_d    = w_done_q | w_ready_i;
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      idx_q       <= 1'b0;
      err_q       <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= 2'b00;
`ifndef SPI_AXI_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: if (|req_i) begin
          addr_q  <= win ? addr_i[2*AXI_ADDR_WIDTH-1:AXI_ADDR_WIDTH] : addr_i[AXI_ADDR_WIDTH-1:0];
          wdata_q <= win ? wdata_i[2*AXI_DATA_WIDTH-1:AXI_DATA_WIDTH] : wdata_i[AXI_DATA_WIDTH-1:0];
          idx_q   <= win;
`ifndef SPI_AXI_ARB_FIXED_PRIO_EN
          last_q  <= win;
`endif
          state_q <= we_i[win] ? WR_REQ : RD_ADDR;
        end
        RD_ADDR: if (ar_ready_i) state_q <= RD_DATA;
        RD_DATA: if (r_valid_i) begin
          rdata_q     <= r_data_i;
          err_q       <= r_resp_i[1];
          rsp_valid_q <= {idx_q, !idx_q};
          state_q     <= IDLE;
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= WR_RESP;
          end
        end
        WR_RESP: if (b_valid_i) begin
          err_q       <= b_resp_i[1];
          rsp_valid_q <= {idx_q, !idx_q};
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_axi_arbiter.sv
// tb_spi_slave_axi_arbiter: directed checks of grant, AXI sequencing, responses and reset.
module tb_spi_slave_axi_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  logic          clk = 1'b0, rstn = 1'b0;
  logic [1:0]    req_i = '0, we_i = '0, gnt_o, rsp_valid_o;
  logic [2*AW-1:0] addr_i = '0;
  logic [2*DW-1:0] wdata_i = '0;
  logic [DW-1:0] rsp_rdata_o, w_data_o, r_data_i = '0;
  logic          rsp_err_o, aw_valid_o, aw_ready_i = 1'b0, w_valid_o, w_last_o, w_ready_i = 1'b0;
  logic [AW-1:0] aw_addr_o, ar_addr_o;
  logic [DW/8-1:0] w_strb_o;
  logic          b_valid_i = 1'b0, b_ready_o, ar_valid_o, ar_ready_i = 1'b1, r_valid_i = 1'b0, r_ready_o;
  logic [1:0]    b_resp_i = '0, r_resp_i = '0;
  int            total = 0, bad = 0;

  spi_slave_axi_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .aw_valid_o(aw_valid_o), .aw_addr_o(aw_addr_o), .aw_ready_i(aw_ready_i),
    .w_valid_o(w_valid_o), .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
    .w_ready_i(w_ready_i), .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_ready_o(b_ready_o),
    .ar_valid_o(ar_valid_o), .ar_addr_o(ar_addr_o), .ar_ready_i(ar_ready_i), .r_valid_i(r_valid_i),
    .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_ready_o(r_ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    we_i[n] = w;
    addr_i[n*AW +: AW] = a;
    wdata_i[n*DW +: DW] = d;
    req_i[n] = 1'b1;
    #1;
  endtask

  task automatic wait_gnt(output logic w);
    for (int k = 0; k < 10 && gnt_o == 2'b00; k++) begin
      @(negedge clk);
      #1;
    end
    check("gnt_timeout", {63'd0, gnt_o != 2'b00}, 64'd1);
    w = gnt_o[1];
  endtask

  task automatic svc_rd(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e,
                        input logic [1:0] clr, input logic [1:0] add);
    @(negedge clk);
    req_i = (req_i & ~clr) | add;
    #1;
    check("ar_valid", {63'd0, ar_valid_o}, 64'd1);
    check("ar_addr", {32'd0, ar_addr_o}, {32'd0, a});
    check("gnt_busy_a", {62'd0, gnt_o}, 64'd0);
    @(negedge clk);
    #1;
    check("r_ready", {63'd0, r_ready_o}, 64'd1);
    check("gnt_busy_r", {62'd0, gnt_o}, 64'd0);
    r_valid_i = 1'b1;
    r_data_i = d;
    r_resp_i = {e, 1'b0};
    @(negedge clk);
    r_valid_i = 1'b0;
    #1;
    check("rd_rsp_valid", {62'd0, rsp_valid_o}, (n == 1) ? 64'd2 : 64'd1);
    check("rd_rdata", rsp_rdata_o, d);
    check("rd_err", {63'd0, rsp_err_o}, {63'd0, e});
  endtask

  task automatic svc_wr(input int n, input logic [AW-1:0] a, input logic [DW-1:0] d, input int awd,
                        input logic [1:0] br, input logic [DW-1:0] prev, input logic [1:0] clr);
    @(negedge clk);
    req_i = req_i & ~clr;
    w_ready_i = 1'b1;
    aw_ready_i = (awd == 0);
    #1;
    check("aw_valid", {63'd0, aw_valid_o}, 64'd1);
    check("w_valid", {63'd0, w_valid_o}, 64'd1);
    check("aw_addr", {32'd0, aw_addr_o}, {32'd0, a});
    check("w_data", w_data_o, d);
    check("w_strb_last", {55'd0, w_strb_o, w_last_o}, 64'h1ff);
    for (int k = 1; k <= awd; k++) begin
      @(negedge clk);
      w_ready_i = 1'b0;
      aw_ready_i = (k == awd);
      #1;
      check("w_done_drop", {63'd0, w_valid_o}, 64'd0);
      check("aw_hold", {63'd0, aw_valid_o}, 64'd1);
    end
    @(negedge clk);
    aw_ready_i = 1'b0;
    w_ready_i = 1'b0;
    #1;
    check("b_ready", {63'd0, b_ready_o}, 64'd1);
    check("wr_valids_off", {62'd0, aw_valid_o, w_valid_o}, 64'd0);
    b_valid_i = 1'b1;
    b_resp_i = br;
    @(negedge clk);
    b_valid_i = 1'b0;
    #1;
    check("wr_rsp_valid", {62'd0, rsp_valid_o}, (n == 1) ? 64'd2 : 64'd1);
    check("wr_err", {63'd0, rsp_err_o}, {63'd0, br[1]});
    check("wr_rdata_keep", rsp_rdata_o, prev);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic w;
    int   cnt [2];
    int   exp_w;
    req_i = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", {62'd0, gnt_o}, 64'd0);
    check("rst_valids", {59'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, 64'd0);
    check("rst_rsp", {61'd0, rsp_valid_o, rsp_err_o}, 64'd0);
    check("rst_rdata", rsp_rdata_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    req_i = 2'b00;

    issue(0, 1'b0, 32'h1000, 64'd0);
    check("t1_gnt", {62'd0, gnt_o}, 64'd1);
    svc_rd(0, 32'h1000, 64'hDEADBEEF_CAFEF00D, 1'b0, 2'b01, 2'b00);

    issue(1, 1'b1, 32'h2008, 64'h1122334455667788);
    check("t2_gnt", {62'd0, gnt_o}, 64'd2);
    svc_wr(1, 32'h2008, 64'h1122334455667788, 3, 2'b00, 64'hDEADBEEF_CAFEF00D, 2'b10);

    @(negedge clk);
    we_i = 2'b00;
    addr_i = {32'h3100, 32'h3000};
    req_i = 2'b11;
    cnt[0] = 0;
    cnt[1] = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      wait_gnt(w);
`ifdef SPI_AXI_ARB_FIXED_PRIO_EN
      exp_w = (i < 4) ? 0 : 1;
`else
      exp_w = i % 2;
`endif
      check("order", {63'd0, w}, 64'(exp_w));
      cnt[int'(w)]++;
      svc_rd(int'(w), w ? 32'h3100 : 32'h3000, 64'h100 + 64'(i), 1'b0,
             (cnt[int'(w)] == 4) ? (w ? 2'b10 : 2'b01) : 2'b00, 2'b00);
    end

    issue(0, 1'b1, 32'h4000, 64'hA5A5_5A5A_0F0F_F0F0);
    check("t4_gnt", {62'd0, gnt_o}, 64'd1);
    svc_wr(0, 32'h4000, 64'hA5A5_5A5A_0F0F_F0F0, 0, 2'b10, 64'h107, 2'b01);
    issue(0, 1'b0, 32'h4008, 64'd0);
    check("t4r_gnt", {62'd0, gnt_o}, 64'd1);
    svc_rd(0, 32'h4008, 64'h55, 1'b0, 2'b01, 2'b00);

    issue(0, 1'b0, 32'h5000, 64'd0);
    check("t5_gnt", {62'd0, gnt_o}, 64'd1);
    svc_rd(0, 32'h5000, 64'h66, 1'b0, 2'b01, 2'b10);
    check("t5_gnt_after_rsp", {62'd0, gnt_o}, 64'd2);
    svc_rd(1, 32'h3100, 64'h77, 1'b0, 2'b10, 2'b00);

    issue(0, 1'b0, 32'h6000, 64'd0);
    check("t6_gnt", {62'd0, gnt_o}, 64'd1);
    @(negedge clk);
    req_i = 2'b00;
    #1;
    check("t6_ar_valid", {63'd0, ar_valid_o}, 64'd1);
    @(negedge clk);
    #1;
    check("t6_r_ready", {63'd0, r_ready_o}, 64'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("t6_async_valids", {59'd0, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, 64'd0);
    check("t6_async_rsp", {61'd0, rsp_valid_o, rsp_err_o}, 64'd0);
    check("t6_async_rdata", rsp_rdata_o, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    req_i = 2'b11;
    #1;
    check("t6_gnt_post_rst", {62'd0, gnt_o}, 64'd1);
    svc_rd(0, 32'h6000, 64'h88, 1'b0, 2'b11, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
